// File: rtl/deserializer_rx_if.sv
// deserializer_rx_if: serial lane input and byte-side outputs of the deserializer
interface deserializer_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       byte_strobe;
  logic       valid_out;
  logic       active;
  modport master (output data_in, input data_out, byte_strobe, valid_out, active);
  modport slave  (input data_in, output data_out, byte_strobe, valid_out, active);
endinterface

// File: rtl/deserializer_rx.sv
// deserializer_rx: bit-sliding comma search, BC_SYNC comma lock, then byte extraction
module deserializer_rx #(
  parameter logic [7:0] COM     = 8'hBC,
  parameter int         BC_SYNC = 4
) (
  input logic              clk_32f,
  input logic              reset,
  deserializer_rx_if.slave bus
);
  // one spare bit so the comma count never wraps before reaching BC_SYNC
  localparam int BW = $clog2(BC_SYNC + 1) + 1;
  typedef enum logic [1:0] {UNALIGNED, ALIGNED, ACTIVE} state_t;
  state_t        r_state, w_state_nx;
  logic [7:0]    r_sr, r_data_out, w_nb, w_data_nx;
  logic [2:0]    r_bit_cnt, w_bit_nx;
  logic [BW-1:0] r_bc_cnt, w_bc_nx, w_bc_inc;
  logic          r_strobe, r_valid, r_active, w_strobe_nx, w_valid_nx, w_com, w_bnd;
  assign w_nb     = {r_sr[6:0], bus.data_in};
  assign w_com    = (w_nb == COM);
  assign w_bnd    = (r_bit_cnt == 3'd7);
  assign w_bc_inc = r_bc_cnt + 1'b1;
  always_comb begin
    w_state_nx  = r_state;
    w_bit_nx    = r_bit_cnt + 3'd1;
    w_bc_nx     = r_bc_cnt;
    w_data_nx   = r_data_out;
    w_strobe_nx = 1'b0;
    w_valid_nx  = 1'b0;
    case (r_state)
      UNALIGNED: begin
        w_bit_nx = 3'd0;
        if (w_com) begin
          w_state_nx = ALIGNED;
          w_bc_nx    = BW'(1);
        end
      end
      ALIGNED: if (w_bnd) begin
        if (w_com) begin
          w_bc_nx = w_bc_inc;
          if (w_bc_inc == BW'(BC_SYNC)) w_state_nx = ACTIVE;
        end else begin
          w_state_nx = UNALIGNED;
          w_bc_nx    = '0;
        end
      end
      ACTIVE: if (w_bnd) begin
        w_data_nx   = w_nb;
        w_strobe_nx = 1'b1;
        w_valid_nx  = !w_com;
      end
      default: w_state_nx = UNALIGNED;
    endcase
  end
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      r_state    <= UNALIGNED;
      r_sr       <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_bc_cnt   <= '0;
      r_data_out <= 8'h00;
      r_strobe   <= 1'b0;
      r_valid    <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_sr       <= w_nb;
      r_bit_cnt  <= w_bit_nx;
      r_bc_cnt   <= w_bc_nx;
      r_data_out <= w_data_nx;
      r_strobe   <= w_strobe_nx;
      r_valid    <= w_valid_nx;
      r_active   <= (w_state_nx == ACTIVE);
    end
  end
  assign bus.data_out    = r_data_out;
  assign bus.byte_strobe = r_strobe;
  assign bus.valid_out   = r_valid;
  assign bus.active      = r_active;
endmodule
